// File: rtl/udp_tx_sched.sv
// Frame scheduler for a UDP sender fed from two payload FIFOs.
// Grants whole frames round-robin, paces them with an inter-frame gap and guards each wait.
module udp_tx_sched #(
    parameter int unsigned PAYLOAD_LEN    = 1024,
    parameter int unsigned IFG_CYCLES     = 12,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] fifo_count0,
    input  logic [10:0] fifo_count1,
    input  logic        sender_busy,
    output logic        frame_start,
    output logic        sel,
    output logic [10:0] frame_index,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        sched_busy,
    output logic [15:0] frames_sent,
    output logic        timeout_err
);

    localparam logic [10:0] PayloadLen  = 11'(PAYLOAD_LEN);
    localparam logic [15:0] GapLast     = 16'(IFG_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StWaitDone,
        StGap
    } state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic        last_grant_q, last_grant_d;
    logic [10:0] idx0_q, idx0_d;
    logic [10:0] idx1_q, idx1_d;
    logic [15:0] frames_q, frames_d;
    // Shared counter: watchdog in the wait states, gap length in StGap.
    logic [15:0] cnt_q, cnt_d;
    logic        rdy0, rdy1;

    assign rdy0 = fifo_count0 >= PayloadLen;
    assign rdy1 = fifo_count1 >= PayloadLen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            idx0_q       <= '0;
            idx1_q       <= '0;
            frames_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            idx0_q       <= idx0_d;
            idx1_q       <= idx1_d;
            frames_q     <= frames_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        idx0_d       = idx0_q;
        idx1_d       = idx1_q;
        frames_d     = frames_q;
        cnt_d        = cnt_q;
        frame_start  = 1'b0;
        timeout_err  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable && !sender_busy && (rdy0 || rdy1)) begin
                    sel_d        = (rdy0 && rdy1) ? ~last_grant_q : rdy1;
                    last_grant_d = sel_d;
                    state_d      = StStart;
                end
            end
            StStart: begin
                frame_start = 1'b1;
                cnt_d       = '0;
                state_d     = StWaitBusy;
            end
            StWaitBusy: begin
                if (sender_busy) begin
                    cnt_d   = '0;
                    state_d = StWaitDone;
                end else if (cnt_q == TimeoutLast) begin
                    timeout_err = 1'b1;
                    cnt_d       = '0;
                    state_d     = StGap;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitDone: begin
                if (!sender_busy) begin
                    if (sel_q) begin
                        idx1_d = idx1_q + 11'd1;
                    end else begin
                        idx0_d = idx0_q + 11'd1;
                    end
                    frames_d = frames_q + 16'd1;
                    cnt_d    = '0;
                    state_d  = StGap;
                end else if (cnt_q == TimeoutLast) begin
                    timeout_err = 1'b1;
                    cnt_d       = '0;
                    state_d     = StGap;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sel             = sel_q;
    assign frame_index     = sel_q ? idx1_q : idx0_q;
    assign sched_busy      = (state_q != StIdle);
    assign frames_sent     = frames_q;
    assign tx_data_length  = 16'(PAYLOAD_LEN + 8);
    assign tx_total_length = 16'(PAYLOAD_LEN + 28);

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: arbitration, gap timing, watchdog, index wrap and reset.
module tb_udp_tx_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [10:0] fifo_count0 = '0;
    logic [10:0] fifo_count1 = '0;
    logic        sender_busy = 1'b0;
    logic        frame_start;
    logic        sel;
    logic [10:0] frame_index;
    logic [15:0] tx_data_length;
    logic [15:0] tx_total_length;
    logic        sched_busy;
    logic [15:0] frames_sent;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    udp_tx_sched dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .fifo_count0     (fifo_count0),
        .fifo_count1     (fifo_count1),
        .sender_busy     (sender_busy),
        .frame_start     (frame_start),
        .sel             (sel),
        .frame_index     (frame_index),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .sched_busy      (sched_busy),
        .frames_sent     (frames_sent),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Counts negedges until frame_start is seen; n = -1 if it never comes.
    task automatic wait_start(output int n);
        n = 0;
        while (!frame_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!frame_start) begin
            check("frame_start_seen", 32'(frame_start), 32'd1);
            n = -1;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sched_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(sched_busy), 32'd0);
    endtask

    // Sender model: goes busy as frame_start is seen, drops after busy_cycles negedges.
    task automatic run_frame(input int busy_cycles, output logic s, output logic [10:0] idx,
                             output int gap);
        wait_start(gap);
        s   = sel;
        idx = frame_index;
        if (gap >= 0) begin
            sender_busy = 1'b1;
            repeat (busy_cycles) @(negedge clk);
            sender_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic        s;
    logic [10:0] idx;
    int          gap;
    int          n;
    logic        saw_start;
    logic [0:3]  exp_sel;
    logic [10:0] exp_idx [4];

    initial begin
        exp_sel    = 4'b0101;
        exp_idx[0] = 11'd0;
        exp_idx[1] = 11'd0;
        exp_idx[2] = 11'd1;
        exp_idx[3] = 11'd1;

        #2 rst_n = 1'b0;
        #1;
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_sched_busy", 32'(sched_busy), 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        check("rst_frame_index", 32'(frame_index), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("data_length", 32'(tx_data_length), 32'd1032);
        check("total_length", 32'(tx_total_length), 32'd1052);
        @(negedge clk);
        rst_n = 1'b1;

        // Threshold boundary and busy-in-idle hold-off
        enable      = 1'b1;
        fifo_count0 = 11'd1023;
        repeat (20) @(negedge clk);
        check("no_grant_1023", 32'(sched_busy), 32'd0);
        fifo_count0 = 11'd1024;
        sender_busy = 1'b1;
        repeat (20) @(negedge clk);
        check("no_grant_sender_busy", 32'(sched_busy), 32'd0);
        sender_busy = 1'b0;

        // Single long frame from source 0
        wait_start(n);
        check("f1_sel", 32'(sel), 32'd0);
        check("f1_index", 32'(frame_index), 32'd0);
        fifo_count0 = '0;
        sender_busy = 1'b1;
        @(negedge clk);
        check("start_pulse_width", 32'(frame_start), 32'd0);
        repeat (1499) @(negedge clk);
        sender_busy = 1'b0;
        wait_idle();
        check("f1_frames_sent", 32'(frames_sent), 32'd1);
        check("f1_index_after", 32'(frame_index), 32'd1);

        // Round robin with both sources ready, gap timing
        do_reset();
        fifo_count0 = 11'd2000;
        fifo_count1 = 11'd2000;
        for (int i = 0; i < 4; i++) begin
            run_frame(3, s, idx, gap);
            if (gap < 0) break;
            check($sformatf("rr_sel_%0d", i), 32'(s), 32'(exp_sel[i]));
            check($sformatf("rr_index_%0d", i), 32'(idx), 32'(exp_idx[i]));
            if (i > 0) check($sformatf("rr_gap_%0d", i), 32'(gap), 32'd14);
        end
        fifo_count0 = '0;
        fifo_count1 = '0;
        wait_idle();
        check("rr_frames_sent", 32'(frames_sent), 32'd4);

        // Watchdog: sender never goes busy
        fifo_count0 = 11'd2000;
        wait_start(n);
        fifo_count0 = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!timeout_err && n < 5000);
        check("timeout_latency", 32'(n), 32'd4095);
        @(negedge clk);
        check("timeout_pulse_width", 32'(timeout_err), 32'd0);
        check("timeout_in_gap", 32'(sched_busy), 32'd1);
        wait_idle();
        check("timeout_frames_sent", 32'(frames_sent), 32'd4);
        check("timeout_index", 32'(frame_index), 32'd2);

        // Index wrap on source 0
        do_reset();
        fifo_count0 = 11'd2000;
        for (int i = 0; i < 2049; i++) begin
            run_frame(2, s, idx, gap);
            if (gap < 0) break;
            if (i == 2047) check("wrap_pre", 32'(idx), 32'd2047);
            if (i == 2048) begin
                fifo_count0 = '0;
                check("wrap_post", 32'(idx), 32'd0);
            end
        end
        wait_idle();
        check("wrap_frames_sent", 32'(frames_sent), 32'd2049);

        // Enable dropped mid-frame: frame completes, nothing new granted
        fifo_count0 = 11'd2000;
        wait_start(n);
        sender_busy = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        sender_busy = 1'b0;
        wait_idle();
        check("en_drop_frames_sent", 32'(frames_sent), 32'd2050);
        saw_start = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (frame_start) saw_start = 1'b1;
        end
        check("en_drop_no_start", 32'(saw_start), 32'd0);

        // Reset mid-frame with source 1 granted
        enable      = 1'b1;
        fifo_count1 = 11'd2000;
        wait_start(n);
        check("pre_rst_sel", 32'(sel), 32'd1);
        sender_busy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_sched_busy", 32'(sched_busy), 32'd0);
        check("midrst_sel", 32'(sel), 32'd0);
        check("midrst_frames_sent", 32'(frames_sent), 32'd0);
        check("midrst_frame_index", 32'(frame_index), 32'd0);
        check("midrst_frame_start", 32'(frame_start), 32'd0);
        check("midrst_timeout_err", 32'(timeout_err), 32'd0);
        @(negedge clk);
        sender_busy = 1'b0;
        rst_n       = 1'b1;
        wait_start(n);
        check("post_rst_sel", 32'(sel), 32'd0);
        check("post_rst_index", 32'(frame_index), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
